// File: rtl/rs_arb.sv
// rtl/rs_arb.sv - two-stream RS decoder arbiter with row byte counting and error pulses.
// Optional WAIT_FIN watchdog enabled by defining RS_ARB_TIMEOUT_EN.
module rs_arb #(
  parameter int ROW_LEN = 240,
  parameter int TO_CYC  = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ts0_rs_req,
  input  logic [1:0] ts0_rs_mode,
  input  logic       ts0_rs_en_in,
  input  logic [7:0] ts0_rs_din,
  input  logic       ts1_rs_req,
  input  logic [1:0] ts1_rs_mode,
  input  logic       ts1_rs_en_in,
  input  logic [7:0] ts1_rs_din,
  input  logic       rs_row_finish,
  output logic       ts0_rs_gnt,
  output logic       ts1_rs_gnt,
  output logic [1:0] rs_mode,
  output logic       rs_en_in,
  output logic [7:0] rs_din,
  output logic       rs_busy,
  output logic       rs_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, WAIT_FIN} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [1:0] mode_q, mode_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
`ifdef RS_ARB_TIMEOUT_EN
  logic [11:0] to_cnt_q, to_cnt_d;
`else
  logic [11:0] to_cyc_unused;
  assign to_cyc_unused = 12'(TO_CYC);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef RS_ARB_TIMEOUT_EN
    to_cnt_d = 12'd0;
`endif
    case (state_q)
      IDLE: begin
        // last_q names the stream served last, so contention goes to the other one
        if (ts0_rs_req && (!ts1_rs_req || last_q)) begin
          state_d = GNT0;
          owner_d = 1'b0;
          gnt0_d  = 1'b1;
          mode_d  = ts0_rs_mode;
          cnt_d   = 8'd0;
        end else if (ts1_rs_req) begin
          state_d = GNT1;
          owner_d = 1'b1;
          gnt1_d  = 1'b1;
          mode_d  = ts1_rs_mode;
          cnt_d   = 8'd0;
        end
      end
      GNT0, GNT1: begin
        if (state_q == GNT0 ? ts1_rs_en_in : ts0_rs_en_in) err_d = 1'b1;
        if (state_q == GNT0 ? ts0_rs_en_in : ts1_rs_en_in) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(ROW_LEN - 1)) state_d = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (ts0_rs_en_in || ts1_rs_en_in) err_d = 1'b1;
        if (rs_row_finish) begin
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          mode_d  = 2'b00;
          last_d  = owner_q;
        end
`ifdef RS_ARB_TIMEOUT_EN
        else if (to_cnt_q == 12'(TO_CYC - 1)) begin
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          mode_d  = 2'b00;
          last_d  = owner_q;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 12'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      mode_q   <= 2'b00;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 8'd0;
`ifdef RS_ARB_TIMEOUT_EN
      to_cnt_q <= 12'd0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
`ifdef RS_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Data path follows the state directly so bytes reach the decoder in the strobe cycle
  assign rs_en_in   = (state_q == GNT0) ? ts0_rs_en_in :
                      (state_q == GNT1) ? ts1_rs_en_in : 1'b0;
  assign rs_din     = (state_q == GNT0) ? ts0_rs_din :
                      (state_q == GNT1) ? ts1_rs_din : 8'h00;
  assign ts0_rs_gnt = gnt0_q;
  assign ts1_rs_gnt = gnt1_q;
  assign rs_mode    = mode_q;
  assign rs_busy    = busy_q;
  assign rs_err     = err_q;

endmodule

// File: tb/tb_rs_arb.sv
// tb/tb_rs_arb.sv - directed self-checking bench for rs_arb.
module tb_rs_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ts0_rs_req, ts0_rs_en_in, ts1_rs_req, ts1_rs_en_in, rs_row_finish;
  logic [1:0] ts0_rs_mode, ts1_rs_mode, rs_mode;
  logic [7:0] ts0_rs_din, ts1_rs_din, rs_din;
  logic       ts0_rs_gnt, ts1_rs_gnt, rs_en_in, rs_busy, rs_err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int fwd_seen = 0;
  int hold = 0;

  always #5 clk = ~clk;

  rs_arb #(.ROW_LEN(240), .TO_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ts0_rs_req(ts0_rs_req), .ts0_rs_mode(ts0_rs_mode),
    .ts0_rs_en_in(ts0_rs_en_in), .ts0_rs_din(ts0_rs_din),
    .ts1_rs_req(ts1_rs_req), .ts1_rs_mode(ts1_rs_mode),
    .ts1_rs_en_in(ts1_rs_en_in), .ts1_rs_din(ts1_rs_din),
    .rs_row_finish(rs_row_finish),
    .ts0_rs_gnt(ts0_rs_gnt), .ts1_rs_gnt(ts1_rs_gnt),
    .rs_mode(rs_mode), .rs_en_in(rs_en_in), .rs_din(rs_din),
    .rs_busy(rs_busy), .rs_err(rs_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    err_seen += 32'(rs_err);
    fwd_seen += 32'(rs_en_in);
  endtask

  task automatic idle_inputs();
    ts0_rs_en_in  = 1'b0;
    ts1_rs_en_in  = 1'b0;
    rs_row_finish = 1'b0;
  endtask

  // n strobes from stream s; noisy adds 5 foreign strobes and early finish pulses
  task automatic row(input bit s, input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      step();
      idle_inputs();
      if (!s) begin
        ts0_rs_en_in = 1'b1;
        ts0_rs_din   = 8'(i);
      end else begin
        ts1_rs_en_in = 1'b1;
        ts1_rs_din   = 8'(255 - i);
      end
      if (noisy && (i % 40 == 10) && i < 210) begin
        ts1_rs_en_in = 1'b1;
        ts1_rs_din   = 8'hEE;
      end
      rs_row_finish = noisy && (i == 100 || i == n - 1);
      mid();
      chk("row_en", 32'(rs_en_in), 32'd1);
      chk("row_din", 32'(rs_din), s ? 32'(255 - i) : 32'(i));
      chk("row_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, s ? 32'd2 : 32'd1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ts0_rs_req = 1'b0; ts1_rs_req = 1'b0;
    ts0_rs_mode = 2'd0; ts1_rs_mode = 2'd0;
    ts0_rs_din = 8'd0; ts1_rs_din = 8'd0;
    idle_inputs();
    step(); step(); mid();
    chk("rst_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    chk("rst_busy", 32'(rs_busy), 32'd0);
    chk("rst_err", 32'(rs_err), 32'd0);
    chk("rst_mode", 32'(rs_mode), 32'd0);
    chk("rst_en", 32'(rs_en_in), 32'd0);
    chk("rst_din", 32'(rs_din), 32'd0);

    // contention after reset goes to ts0
    step(); reset_n = 1'b1;
    ts0_rs_req = 1'b1; ts1_rs_req = 1'b1; ts0_rs_mode = 2'd2; ts1_rs_mode = 2'd1;
    mid();
    chk("idle_no_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    step(); ts0_rs_req = 1'b0; mid();
    chk("c1_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd1);
    chk("c1_mode", 32'(rs_mode), 32'd2);
    chk("c1_busy", 32'(rs_busy), 32'd1);

    err_seen = 0; fwd_seen = 0;
    row(1'b0, 240, 1'b1);
    step(); idle_inputs(); ts0_rs_en_in = 1'b1; ts0_rs_din = 8'hF1; mid();
    chk("s241_en", 32'(rs_en_in), 32'd0);
    chk("s241_din", 32'(rs_din), 32'd0);
    chk("s241_gnt", 32'(ts0_rs_gnt), 32'd1);
    step(); idle_inputs(); mid();
    chk("s241_err", 32'(rs_err), 32'd1);
    chk("noisy_err_cnt", 32'(err_seen), 32'd6);
    chk("noisy_fwd_cnt", 32'(fwd_seen), 32'd240);
    repeat (3) begin step(); mid(); end
    chk("err_one_cycle", 32'(err_seen), 32'd6);
    step(); rs_row_finish = 1'b1; mid();
    chk("fin_cycle_gnt", 32'(ts0_rs_gnt), 32'd1);
    step(); rs_row_finish = 1'b0; mid();
    chk("gap_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    chk("gap_busy", 32'(rs_busy), 32'd0);
    step(); ts1_rs_req = 1'b0; mid();
    chk("c2_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd2);
    chk("c2_mode", 32'(rs_mode), 32'd1);

    err_seen = 0; fwd_seen = 0;
    row(1'b1, 240, 1'b0);
    step(); idle_inputs(); mid();
    repeat (8) begin step(); mid(); end
    chk("ts1_err_cnt", 32'(err_seen), 32'd0);
    chk("ts1_fwd_cnt", 32'(fwd_seen), 32'd240);
    step(); rs_row_finish = 1'b1; ts0_rs_req = 1'b1; ts1_rs_req = 1'b1; mid();
    chk("ts1_fin_gnt", 32'(ts1_rs_gnt), 32'd1);
    step(); rs_row_finish = 1'b0; mid();
    chk("c3_idle", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    step(); ts0_rs_req = 1'b0; ts1_rs_req = 1'b0; mid();
    chk("c3_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd1);
    chk("c3_mode", 32'(rs_mode), 32'd2);

    // reset in the middle of a row
    row(1'b0, 100, 1'b0);
    step(); reset_n = 1'b0; ts0_rs_en_in = 1'b1; ts0_rs_din = 8'd100; mid();
    chk("mrst_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    chk("mrst_busy", 32'(rs_busy), 32'd0);
    chk("mrst_en", 32'(rs_en_in), 32'd0);
    chk("mrst_din", 32'(rs_din), 32'd0);
    chk("mrst_mode", 32'(rs_mode), 32'd0);
    step(); reset_n = 1'b1; idle_inputs(); ts1_rs_req = 1'b1; ts1_rs_mode = 2'd3; mid();
    chk("post_rst_idle", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd0);
    step(); ts1_rs_req = 1'b0; mid();
    chk("post_rst_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd2);
    chk("post_rst_mode", 32'(rs_mode), 32'd3);
    row(1'b1, 240, 1'b0);
    step(); idle_inputs(); rs_row_finish = 1'b1; mid();
    step(); rs_row_finish = 1'b0; mid();
    chk("post_rst_release", 32'(ts1_rs_gnt), 32'd0);

    // clean ts0 row, finish 10 cycles after the last byte
    step(); ts0_rs_req = 1'b1; ts0_rs_mode = 2'd0; mid();
    step(); ts0_rs_req = 1'b0; mid();
    chk("clean_gnt", {30'd0, ts1_rs_gnt, ts0_rs_gnt}, 32'd1);
    chk("clean_mode", 32'(rs_mode), 32'd0);
    err_seen = 0; fwd_seen = 0;
    row(1'b0, 240, 1'b0);
    step(); idle_inputs(); mid();
    repeat (8) begin step(); mid(); end
    step(); rs_row_finish = 1'b1; mid();
    chk("clean_fin_gnt", 32'(ts0_rs_gnt), 32'd1);
    step(); rs_row_finish = 1'b0; mid();
    chk("clean_drop", 32'(ts0_rs_gnt), 32'd0);
    chk("clean_err_cnt", 32'(err_seen), 32'd0);
    chk("clean_fwd_cnt", 32'(fwd_seen), 32'd240);

    // no finish: watchdog release or indefinite hold
    step(); ts0_rs_req = 1'b1; mid();
    step(); ts0_rs_req = 1'b0; mid();
    chk("wd_gnt", 32'(ts0_rs_gnt), 32'd1);
    row(1'b0, 240, 1'b0);
    err_seen = 0; hold = 0;
`ifdef RS_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      step(); idle_inputs(); mid();
      hold += 32'(ts0_rs_gnt);
    end
    chk("wd_hold", 32'(hold), 32'd16);
    step(); mid();
    chk("wd_drop", 32'(ts0_rs_gnt), 32'd0);
    chk("wd_err", 32'(rs_err), 32'd1);
    chk("wd_busy", 32'(rs_busy), 32'd0);
    step(); mid();
    chk("wd_err_cnt", 32'(err_seen), 32'd1);
`else
    for (int k = 0; k < 1000; k++) begin
      step(); idle_inputs(); mid();
      hold += 32'(ts0_rs_gnt);
    end
    chk("nowd_hold", 32'(hold), 32'd1000);
    chk("nowd_err_cnt", 32'(err_seen), 32'd0);
    chk("nowd_busy", 32'(rs_busy), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
